biu_prefetch: RTL and testbench
===============================

// Module: biu_prefetch
// PURPOSE
//  Bus-interface prefetch unit for the 8086-class core. Generates segment:offset code addresses,
//  streams bytes from the synchronous ROM port into a parametrised instruction queue, and offers a
//  multi-byte peek window to the decoder. Sits between the ROM interface and the execution unit;
//  the decoder redirects it with a flush on every jump/call/interrupt.
// PARAMETERS
//  ADDR_W      20       physical address width; all address arithmetic is mod 2^ADDR_W
//  SEG_SHIFT   4        segment left-shift applied in physical address generation
//  QUEUE_DEPTH 6        queue capacity in bytes (>=2)
//  PEEK        2        head bytes visible per cycle; max bytes popped per cycle (1..QUEUE_DEPTH)
//  RESET_CS    16'hFFFF code segment after reset
//  RESET_IP    16'h0000 fetch offset after reset
// PORTS
//  clk       in  1                   clock, all state on rising edge
//  rst       in  1                   reset, asynchronous, active-high
//  rom_en    out 1                   ROM read strobe; data is returned on rom_data one cycle later
//  rom_addr  out ADDR_W              ROM byte address, valid while rom_en=1
//  rom_data  in  8                   ROM read data
//  hold      in  1                   1 = issue no new ROM reads (in-flight read still completes)
//  flush     in  1                   discard queue and in-flight byte, restart fetch at flush_cs:flush_ip
//  flush_cs  in  16                  new code segment, sampled when flush=1
//  flush_ip  in  16                  new offset, sampled when flush=1
//  q_data    out 8*PEEK              head bytes; byte k in bits [8k+7:8k], valid if k<q_count
//  q_count   out $clog2(QUEUE_DEPTH+1) bytes currently held
//  q_ip      out 16                  offset of the head byte
//  pop_cnt   in  $clog2(PEEK+1)      bytes consumed this cycle
//  `ifdef BIU_PERF_EN: perf_flush out 16, perf_empty out 16 (see CONFIGURATION)
// BEHAVIOUR
//  Reset: rom_en=0, rom_addr=0, q_count=0, q_data=0, q_ip=RESET_IP; fetch cs:ip=RESET_CS:RESET_IP.
//  Physical address = ({cs,SEG_SHIFT'b0} + ip) mod 2^ADDR_W; fetch ip increments mod 2^16 and wraps
//   within the segment.
//  Issue rule: rom_en=1 in a cycle iff !rst && !hold && !flush && (q_count + inflight) < QUEUE_DEPTH.
//   Reads are pipelined, at most one per cycle; inflight is 0 or 1.
//  Fill: byte returned on rom_data the cycle after rom_en is written at the tail; q_count rises on
//   the next edge. First rom_en occurs in the first cycle after rst deasserts.
//  Pop: pop_cnt <= q_count removes pop_cnt bytes from the head and advances q_ip by pop_cnt
//   mod 2^16. pop_cnt > q_count: the whole pop is ignored (no state change).
//  Pop and fill in the same cycle: both apply; q_count_next = q_count - pop_cnt + fill.
//  Full: q_count + inflight = QUEUE_DEPTH -> rom_en=0 until a pop frees a slot (re-issue same cycle).
//  Flush: overrides pop and fill. Next edge: q_count=0, q_ip=flush_ip, fetch cs:ip=flush_cs:flush_ip.
//   Any read issued before or in the flush cycle is discarded on return. rom_en=0 in the flush cycle;
//   the first new address is issued the following cycle, unless flush or hold is high in that cycle.
//  Reset mid-fetch: everything returns to reset values asynchronously; the returning byte is dropped.
//  Storage: circular buffer with head/tail pointers wrapping at QUEUE_DEPTH (non-power-of-2 legal).
// CONFIGURATION
//  BIU_PERF_EN defined: perf_flush counts accepted flushes; perf_empty counts cycles with
//   q_count=0 and !flush. Both saturate at 16'hFFFF and reset to 0.
//  BIU_PERF_EN undefined: both perf ports and both counters are absent; all other behaviour is
//   identical.
// STRUCTURE
//  Package biu_pkg: physical-address function phys_addr(cs,ip), reset-vector constants, and the
//   QUEUE_DEPTH/PEEK count-width localparams, shared with the future EU memory port.
//  Sub-module biu_queue: circular byte FIFO with push, variable pop (0..PEEK), peek window, and
//   clear. biu_prefetch holds the fetch counters, in-flight/kill tracking, and the issue logic.
// TESTING
//  1 Reset release, no pops -> rom_addr=20'hFFFF0,FFFF1,... on consecutive cycles; rom_en drops after
//    6 issues; q_count=6.
//  2 Queue full, pop_cnt=2 -> q_count=4, q_ip+=2, rom_en re-asserts in the same cycle;
//    pop_cnt=3 with PEEK=2 is illegal and is not driven.
//  3 flush cs=16'h1234 ip=16'h0010 with a read in flight -> q_count=0, stale byte never enters
//    the queue, next rom_addr=20'h12350.
//  4 flush ip=16'hFFFE cs=16'h0000 -> rom_addr sequence 0FFFE,0FFFF,00000 (offset wraps in segment).
//  5 q_count=1, pop_cnt=2 -> ignored: q_count stays 1, q_ip unchanged. Simultaneous pop 1 + fill ->
//    q_count unchanged, q_data[7:0] = former byte 1.
//  6 hold=1 for 5 cycles -> no rom_en, in-flight byte still lands. Under BIU_PERF_EN: 3 flushes ->
//    perf_flush=3.

Source files
------------

// File: rtl/biu_pkg.sv
// biu_pkg
//   Shared definitions for the bus-interface unit: default geometry of the
//   prefetch path, the reset vector, count/pop field widths, and the
//   segment:offset to physical address translation. The execution unit's
//   memory port reuses the same translation.
package biu_pkg;

  localparam int BIU_ADDR_W      = 20;
  localparam int BIU_SEG_SHIFT   = 4;
  localparam int BIU_QUEUE_DEPTH = 6;
  localparam int BIU_PEEK        = 2;

  localparam logic [15:0] BIU_RESET_CS = 16'hFFFF;
  localparam logic [15:0] BIU_RESET_IP = 16'h0000;

  localparam int BIU_Q_CNT_W = $clog2(BIU_QUEUE_DEPTH + 1);
  localparam int BIU_POP_W   = $clog2(BIU_PEEK + 1);

  // Returns the untruncated 32-bit sum; callers cut it to their address
  // width, which gives the mod 2^ADDR_W behaviour (valid for ADDR_W <= 32).
  function automatic logic [31:0] phys_addr(input logic [15:0] cs,
                                            input logic [15:0] ip,
                                            input int seg_shift = BIU_SEG_SHIFT);
    return ({16'h0000, cs} << seg_shift) + {16'h0000, ip};
  endfunction

endpackage

// File: rtl/biu_prefetch_if.sv
// biu_prefetch_if
//   Bundles the ROM port, decoder control and queue peek window of the
//   prefetch unit.
//   slave  : the prefetch unit (drives rom_en/rom_addr and the queue view)
//   master : the surrounding core/ROM (drives rom_data, hold, flush, pops)
//   Signals:
//     rom_en, rom_addr   ROM read strobe and byte address
//     rom_data           ROM data, returned one cycle after rom_en
//     hold               suppress new reads
//     flush, flush_cs,   redirect fetch to flush_cs:flush_ip
//     flush_ip
//     q_data, q_count,   head bytes, byte count, offset of head byte
//     q_ip
//     pop_cnt            bytes consumed this cycle
interface biu_prefetch_if
  import biu_pkg::*;
#(
  parameter int ADDR_W      = BIU_ADDR_W,
  parameter int QUEUE_DEPTH = BIU_QUEUE_DEPTH,
  parameter int PEEK        = BIU_PEEK
);
  localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);
  localparam int POP_W = $clog2(PEEK + 1);

  logic              rom_en;
  logic [ADDR_W-1:0] rom_addr;
  logic [7:0]        rom_data;
  logic              hold;
  logic              flush;
  logic [15:0]       flush_cs;
  logic [15:0]       flush_ip;
  logic [8*PEEK-1:0] q_data;
  logic [CNT_W-1:0]  q_count;
  logic [15:0]       q_ip;
  logic [POP_W-1:0]  pop_cnt;

  modport slave (
    output rom_en, rom_addr, q_data, q_count, q_ip,
    input  rom_data, hold, flush, flush_cs, flush_ip, pop_cnt
  );

  modport master (
    input  rom_en, rom_addr, q_data, q_count, q_ip,
    output rom_data, hold, flush, flush_cs, flush_ip, pop_cnt
  );

endinterface

// File: rtl/biu_queue.sv
// biu_queue
//   Circular byte FIFO for the instruction prefetch queue. Head/tail
//   pointers wrap at DEPTH, so non-power-of-two depths are fine.
//   Ports:
//     clk, rst     clock, asynchronous active-high reset
//     clear        drop all contents (takes priority over push/pop)
//     push         write push_data at the tail
//     push_data    byte to write
//     pop_cnt      bytes removed from the head; caller guarantees
//                  pop_cnt <= q_count
//     q_data       PEEK head bytes, byte k at [8k+7:8k]; bytes at or
//                  beyond q_count read as zero
//     q_count      bytes held
module biu_queue
  import biu_pkg::*;
#(
  parameter int DEPTH = BIU_QUEUE_DEPTH,
  parameter int PEEK  = BIU_PEEK
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           clear,
  input  logic                           push,
  input  logic [7:0]                     push_data,
  input  logic [$clog2(PEEK+1)-1:0]      pop_cnt,
  output logic [8*PEEK-1:0]              q_data,
  output logic [$clog2(DEPTH+1)-1:0]     q_count
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);

  logic [7:0]       mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;
  logic             push_ok;
  logic [CNT_W-1:0] count_nxt;

  // n never exceeds DEPTH, so one conditional subtract is enough.
  function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p, input int n);
    int s;
    s = int'(p) + n;
    if (s >= DEPTH) s = s - DEPTH;
    return PTR_W'(s);
  endfunction

  always_comb begin
    // A push is accepted when there is room after this cycle's pop.
    push_ok   = push && ((int'(count) - int'(pop_cnt)) < DEPTH);
    count_nxt = CNT_W'(int'(count) - int'(pop_cnt) + (push_ok ? 1 : 0));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (clear) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push_ok) tail <= ptr_add(tail, 1);
      head  <= ptr_add(head, int'(pop_cnt));
      count <= count_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !clear && push_ok) mem[tail] <= push_data;
  end

  always_comb begin
    q_data = '0;
    for (int k = 0; k < PEEK; k++) begin
      if (k < int'(count)) q_data[8*k +: 8] = mem[ptr_add(head, k)];
    end
  end

  assign q_count = count;

endmodule

// File: rtl/biu_prefetch.sv
// biu_prefetch
//   Prefetch half of the bus-interface unit. Keeps the fetch cs:ip, issues
//   pipelined single-byte ROM reads while the queue has room, writes the
//   returned bytes into biu_queue and tracks the offset of the head byte.
//   A flush redirects fetch and discards the queue and any in-flight byte.
//   Ports:
//     clk, rst     clock, asynchronous active-high reset
//     bus          biu_prefetch_if.slave (ROM port, hold/flush, queue view)
//     perf_flush   accepted flush count, saturating    (BIU_PERF_EN only)
//     perf_empty   cycles with empty queue and no flush (BIU_PERF_EN only)
//   Optional feature macro: BIU_PERF_EN adds the two performance counters.
module biu_prefetch
  import biu_pkg::*;
#(
  parameter int          ADDR_W      = BIU_ADDR_W,
  parameter int          SEG_SHIFT   = BIU_SEG_SHIFT,
  parameter int          QUEUE_DEPTH = BIU_QUEUE_DEPTH,
  parameter int          PEEK        = BIU_PEEK,
  parameter logic [15:0] RESET_CS    = BIU_RESET_CS,
  parameter logic [15:0] RESET_IP    = BIU_RESET_IP
) (
  input  logic          clk,
  input  logic          rst,
  biu_prefetch_if.slave bus
`ifdef BIU_PERF_EN
  ,
  output logic [15:0]   perf_flush,
  output logic [15:0]   perf_empty
`endif
);
  localparam int POP_W = $clog2(PEEK + 1);

  logic [15:0]       fetch_cs;
  logic [15:0]       fetch_ip;
  logic [15:0]       q_ip_r;
  logic              inflight;
  logic              pop_ok;
  logic [POP_W-1:0]  pop_eff;
  logic              fill;
  logic              issue;
  logic [ADDR_W-1:0] fetch_addr;

  always_comb begin
    // An over-long pop is dropped as a whole.
    pop_ok  = int'(bus.pop_cnt) <= int'(bus.q_count);
    pop_eff = pop_ok ? bus.pop_cnt : '0;
    // A byte returning during a flush belongs to the old stream.
    fill    = inflight && !bus.flush;
    // Occupancy counts the slot reserved by the in-flight read and
    // credits this cycle's pop, so a pop from full re-issues at once.
    issue   = !rst && !bus.hold && !bus.flush &&
              ((int'(bus.q_count) - int'(pop_eff) + int'(inflight)) < QUEUE_DEPTH);
  end

  assign fetch_addr   = ADDR_W'(phys_addr(fetch_cs, fetch_ip, SEG_SHIFT));
  assign bus.rom_en   = issue;
  assign bus.rom_addr = issue ? fetch_addr : '0;
  assign bus.q_ip     = q_ip_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_cs <= RESET_CS;
      fetch_ip <= RESET_IP;
      q_ip_r   <= RESET_IP;
      inflight <= 1'b0;
    end else if (bus.flush) begin
      fetch_cs <= bus.flush_cs;
      fetch_ip <= bus.flush_ip;
      q_ip_r   <= bus.flush_ip;
      inflight <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) fetch_ip <= fetch_ip + 16'd1;
      q_ip_r <= q_ip_r + 16'(pop_eff);
    end
  end

  biu_queue #(
    .DEPTH (QUEUE_DEPTH),
    .PEEK  (PEEK)
  ) u_queue (
    .clk       (clk),
    .rst       (rst),
    .clear     (bus.flush),
    .push      (fill),
    .push_data (bus.rom_data),
    .pop_cnt   (pop_eff),
    .q_data    (bus.q_data),
    .q_count   (bus.q_count)
  );

`ifdef BIU_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_flush <= 16'h0000;
      perf_empty <= 16'h0000;
    end else begin
      if (bus.flush && perf_flush != 16'hFFFF) perf_flush <= perf_flush + 16'd1;
      if (bus.q_count == '0 && !bus.flush && perf_empty != 16'hFFFF)
        perf_empty <= perf_empty + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_biu_prefetch.sv
// tb_biu_prefetch
//   Directed plus randomized bench for biu_prefetch. A byte-queue reference
//   model tracks the expected queue contents, head offset and fetch address;
//   a ROM model returns a fixed function of the address one cycle after
//   rom_en. Build with BIU_PERF_EN defined to also cover the perf counters.
module tb_biu_prefetch;
  import biu_pkg::*;

  localparam int DEPTH = BIU_QUEUE_DEPTH;
  localparam int PEEK  = BIU_PEEK;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  biu_prefetch_if bus ();
`ifdef BIU_PERF_EN
  logic [15:0] perf_flush;
  logic [15:0] perf_empty;
`endif

  biu_prefetch dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef BIU_PERF_EN
    ,
    .perf_flush (perf_flush),
    .perf_empty (perf_empty)
`endif
  );

  int tests = 0;
  int fails = 0;

  // reference model state
  logic [7:0]  mq[$];
  logic [15:0] m_qip, m_cs, m_ip;
  bit          m_inf;
  logic [19:0] m_inf_addr;
  int          m_pflush, m_pempty;
  // inputs of the current cycle
  bit          c_hold, c_flush;
  logic [15:0] c_cs, c_ip;
  int          c_pop;

  function automatic logic [7:0] rom_fn(input logic [19:0] a);
    return a[7:0] ^ {a[11:8], a[19:16]} ^ 8'h5A;
  endfunction

  always @(posedge clk) begin
    if (bus.rom_en) bus.rom_data <= rom_fn(bus.rom_addr);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int eff_pop();
    return (c_pop <= mq.size()) ? c_pop : 0;
  endfunction

  function automatic bit exp_en();
    return !c_hold && !c_flush && ((mq.size() - eff_pop() + int'(m_inf)) < DEPTH);
  endfunction

  function automatic logic [19:0] exp_addr();
    logic [31:0] full;
    full = ({16'h0000, m_cs} << 4) + {16'h0000, m_ip};
    return exp_en() ? full[19:0] : 20'h0;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_qip    = BIU_RESET_IP;
    m_cs     = BIU_RESET_CS;
    m_ip     = BIU_RESET_IP;
    m_inf    = 1'b0;
    m_pflush = 0;
    m_pempty = 0;
  endtask

  // Called just after a falling edge: apply inputs, then compare.
  task automatic drive(input bit h, input bit f, input logic [15:0] cs,
                       input logic [15:0] ip, input int pop);
    c_hold = h; c_flush = f; c_cs = cs; c_ip = ip; c_pop = pop;
    bus.hold     = h;
    bus.flush    = f;
    bus.flush_cs = cs;
    bus.flush_ip = ip;
    bus.pop_cnt  = BIU_POP_W'(pop);
    #1;
    check("rom_en",   32'(bus.rom_en),   32'(exp_en()));
    check("rom_addr", 32'(bus.rom_addr), 32'(exp_addr()));
    check("q_count",  32'(bus.q_count),  32'(mq.size()));
    check("q_ip",     32'(bus.q_ip),     32'(m_qip));
    for (int k = 0; k < PEEK; k++) begin
      if (k < mq.size()) check("q_data", 32'(bus.q_data[8*k +: 8]), 32'(mq[k]));
    end
`ifdef BIU_PERF_EN
    check("perf_flush", 32'(perf_flush), 32'(m_pflush));
    check("perf_empty", 32'(perf_empty), 32'(m_pempty));
`endif
  endtask

  task automatic advance();
    bit          en;
    logic [19:0] addr;
    int          p;
    en   = exp_en();
    addr = exp_addr();
    p    = eff_pop();
    @(posedge clk);
    if (c_flush && m_pflush < 65535) m_pflush++;
    if (mq.size() == 0 && !c_flush && m_pempty < 65535) m_pempty++;
    if (c_flush) begin
      mq.delete();
      m_qip = c_ip;
      m_cs  = c_cs;
      m_ip  = c_ip;
      m_inf = 1'b0;
    end else begin
      repeat (p) void'(mq.pop_front());
      m_qip = m_qip + 16'(p);
      if (m_inf) mq.push_back(rom_fn(m_inf_addr));
      m_inf = en;
      if (en) begin
        m_inf_addr = addr;
        m_ip       = m_ip + 16'd1;
      end
    end
    @(negedge clk);
  endtask

  task automatic cyc(input bit h, input bit f, input logic [15:0] cs,
                     input logic [15:0] ip, input int pop);
    drive(h, f, cs, ip, pop);
    advance();
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_rom_en"},   32'(bus.rom_en),   32'd0);
    check({tag, "_rom_addr"}, 32'(bus.rom_addr), 32'd0);
    check({tag, "_q_count"},  32'(bus.q_count),  32'd0);
    check({tag, "_q_data"},   32'(bus.q_data),   32'd0);
    check({tag, "_q_ip"},     32'(bus.q_ip),     32'(BIU_RESET_IP));
  endtask

  initial begin
    logic [19:0] t4_addr [3];
    t4_addr[0] = 20'h0FFFE; t4_addr[1] = 20'h0FFFF; t4_addr[2] = 20'h00000;

    rst = 1'b1;
    bus.hold = 1'b0; bus.flush = 1'b0; bus.flush_cs = '0; bus.flush_ip = '0;
    bus.pop_cnt = '0; bus.rom_data = '0;
    model_reset();
    repeat (2) @(negedge clk);
    reset_checks("reset");
    rst = 1'b0;

    // 1: fill from the reset vector
    drive(0, 0, 16'h0, 16'h0, 0);
    check("t1_first_addr", 32'(bus.rom_addr), 32'h000FFFF0);
    advance();
    repeat (7) cyc(0, 0, 16'h0, 16'h0, 0);
    drive(0, 0, 16'h0, 16'h0, 0);
    check("t1_full_count", 32'(bus.q_count), 32'd6);
    check("t1_full_en",    32'(bus.rom_en),  32'd0);
    advance();

    // 2: pop two from full, re-issue in the same cycle
    drive(0, 0, 16'h0, 16'h0, 2);
    check("t2_reissue", 32'(bus.rom_en), 32'd1);
    advance();
    drive(0, 0, 16'h0, 16'h0, 0);
    check("t2_count", 32'(bus.q_count), 32'd4);
    check("t2_q_ip",  32'(bus.q_ip),    32'h2);
    advance();

    // 3: flush with a read in flight
    drive(0, 1, 16'h1234, 16'h0010, 0);
    check("t3_flush_en", 32'(bus.rom_en), 32'd0);
    advance();
    drive(0, 0, 16'h0, 16'h0, 0);
    check("t3_count", 32'(bus.q_count),  32'd0);
    check("t3_addr",  32'(bus.rom_addr), 32'h00012350);
    advance();
    repeat (4) cyc(0, 0, 16'h0, 16'h0, 1);

    // 4: offset wraps inside the segment
    cyc(0, 1, 16'h0000, 16'hFFFE, 0);
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 16'h0, 16'h0, 0);
      check("t4_wrap_addr", 32'(bus.rom_addr), 32'(t4_addr[i]));
      advance();
    end

    // 5: over-long pop ignored; pop one with a simultaneous fill
    cyc(0, 1, 16'h0000, 16'h0100, 0);
    cyc(0, 0, 16'h0, 16'h0, 0);
    cyc(1, 0, 16'h0, 16'h0, 0);
    drive(1, 0, 16'h0, 16'h0, 2);
    check("t5_count_before", 32'(bus.q_count), 32'd1);
    advance();
    drive(1, 0, 16'h0, 16'h0, 0);
    check("t5_ignored_count", 32'(bus.q_count), 32'd1);
    check("t5_ignored_ip",    32'(bus.q_ip),    32'h0100);
    advance();
    cyc(0, 0, 16'h0, 16'h0, 0);
    cyc(1, 0, 16'h0, 16'h0, 1);
    drive(1, 0, 16'h0, 16'h0, 0);
    check("t5_popfill_count", 32'(bus.q_count),    32'd1);
    check("t5_popfill_byte",  32'(bus.q_data[7:0]), 32'(rom_fn(20'h00101)));
    advance();

    // 6: hold for five cycles, in-flight byte still lands
    cyc(0, 0, 16'h0, 16'h0, 0);
    for (int i = 0; i < 5; i++) begin
      drive(1, 0, 16'h0, 16'h0, 0);
      check("t6_hold_en", 32'(bus.rom_en), 32'd0);
      advance();
    end
    drive(1, 0, 16'h0, 16'h0, 0);
    check("t6_count", 32'(bus.q_count), 32'd2);
    advance();

    // randomized traffic
    for (int i = 0; i < 800; i++) begin
      cyc($urandom_range(0, 4) == 0, $urandom_range(0, 19) == 0,
          16'($urandom), 16'($urandom), int'($urandom_range(0, PEEK)));
    end

    // reset in the middle of a fetch
    cyc(0, 0, 16'h0, 16'h0, 0);
    drive(0, 0, 16'h0, 16'h0, 0);
    #2 rst = 1'b1;
    #1 reset_checks("midreset");
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) cyc(0, 0, 16'h0, 16'h0, 0);

    // three flushes after a clean reset
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 16'h2000, 16'(16 * i), 0);
      cyc(0, 0, 16'h0, 16'h0, 1);
    end
    drive(0, 0, 16'h0, 16'h0, 0);
`ifdef BIU_PERF_EN
    check("perf_flush_3", 32'(perf_flush), 32'd3);
`endif
    advance();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
